// File: rtl/butterfly_pair_feeder.sv
// Radix-2 DIF operand feeder: buffers the first half of each frame, then pairs x[k] with x[k+N/2].
// Optional build macro BFLY_FEED_SCALE_EN halves A and B (arithmetic shift) for per-stage scaling.

package butterfly_pair_feeder_pkg;
  localparam int FP_W = 16;

  typedef struct packed {
    logic signed [FP_W-1:0] r;
    logic signed [FP_W-1:0] i;
  } complex_fp_t;
endpackage

module butterfly_pair_feeder
  import butterfly_pair_feeder_pkg::*;
#(
  parameter int N     = 64,
  parameter int IDX_W = $clog2(N/2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  complex_fp_t      in_data,
  output complex_fp_t      A,
  output complex_fp_t      B,
  output logic [IDX_W-1:0] tw_idx,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic             frame_done
);

  localparam int HALF = N / 2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(HALF - 1);

  typedef enum logic {S_FILL, S_PAIR} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  complex_fp_t      r_buf [HALF];

  logic w_in_xfer, w_out_xfer, w_load;

  function automatic complex_fp_t f_scale(input complex_fp_t x);
    complex_fp_t y;
`ifdef BFLY_FEED_SCALE_EN
    y.r = x.r >>> 1;
    y.i = x.i >>> 1;
`else
    y = x;
`endif
    return y;
  endfunction

  // FILL never backpressures: the stalled last pair of the previous frame
  // no longer needs the buffer, so the next frame may start filling.
  assign in_ready   = (r_state == S_FILL) | ~pair_valid | pair_ready;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = pair_valid & pair_ready;
  assign w_load     = w_in_xfer & (r_state == S_PAIR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_in_xfer) begin
      if (r_cnt == LAST) begin
        w_cnt_nxt   = '0;
        w_state_nxt = (r_state == S_FILL) ? S_PAIR : S_FILL;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer && r_state == S_FILL)
      r_buf[r_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A          <= '0;
      B          <= '0;
      tw_idx     <= '0;
      pair_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_out_xfer && (tw_idx == LAST);
      if (w_load) begin
        A          <= f_scale(r_buf[r_cnt]);
        B          <= f_scale(in_data);
        tw_idx     <= r_cnt;
        pair_valid <= 1'b1;
      end else if (w_out_xfer) begin
        pair_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_butterfly_pair_feeder.sv
// Directed bench for butterfly_pair_feeder at N=8; expected pairs are hand-derived from the sample tables.
module tb_butterfly_pair_feeder;
  import butterfly_pair_feeder_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             pair_ready = 1'b0;
  complex_fp_t      in_data = '0;
  logic             in_ready;
  complex_fp_t      A, B;
  logic [IDX_W-1:0] tw_idx;
  logic             pair_valid;
  logic             frame_done;

  butterfly_pair_feeder #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .A(A), .B(B), .tw_idx(tw_idx),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_done = 0;
  int q_a[$], q_ai[$], q_b[$], q_tw[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sc(input int v);
`ifdef BFLY_FEED_SCALE_EN
    return v >>> 1;
`else
    return v;
`endif
  endfunction

  // Output transfers complete at the next rising edge iff valid&ready here.
  always @(negedge clk) begin
    if (reset) begin
      if (pair_valid && pair_ready) begin
        q_a.push_back(int'(A.r));
        q_ai.push_back(int'(A.i));
        q_b.push_back(int'(B.r));
        q_tw.push_back(int'(tw_idx));
      end
      if (frame_done) n_done++;
    end
  end

  task automatic clear_log();
    q_a.delete(); q_ai.delete(); q_b.delete(); q_tw.delete();
    n_done = 0;
  endtask

  task automatic send(input int r, input int i);
    in_data.r = 16'(r);
    in_data.i = 16'(i);
    in_valid  = 1'b1;
    for (int t = 0; t <= 50; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t == 50) chk("send_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_run(input int first, input int last);
    for (int k = first; k <= last; k++) send(k, -k);
  endtask

  task automatic drain();
    pair_ready = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      if (!pair_valid) break;
      if (t == 20) chk("drain", pair_valid, 0);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_pairs(input string tag, input int first, input int a0, input int cnt);
    chk({tag, "_count"}, (q_a.size() >= first + cnt), 1);
    for (int k = 0; k < cnt; k++) begin
      if (first + k < q_a.size()) begin
        chk($sformatf("%s_A%0d", tag, k),  q_a[first+k],  sc(a0 + k));
        chk($sformatf("%s_Ai%0d", tag, k), q_ai[first+k], sc(-(a0 + k)));
        chk($sformatf("%s_B%0d", tag, k),  q_b[first+k],  sc(a0 + 4 + k));
        chk($sformatf("%s_tw%0d", tag, k), q_tw[first+k], k);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pv", pair_valid, 0);
    chk("rst_fd", frame_done, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_tw", tw_idx, 0);

    // 2: streaming with latency check around x[4]
    clear_log();
    pair_ready = 1'b1;
    send_run(0, 3);
    chk("t2_pv_fill", pair_valid, 0);
    send(4, -4);
    chk("t2_pv_lat", pair_valid, 1);
    chk("t2_A0", A.r, sc(0));
    chk("t2_B0", B.r, sc(4));
    chk("t2_tw0", tw_idx, 0);
    send_run(5, 7);
    drain();
    chk_pairs("t2", 0, 0, 4);
    chk("t2_npairs", q_a.size(), 4);
    chk("t2_done", n_done, 1);

    // 3: stall pair (1,5) for 5 cycles with junk offered on the input
    clear_log();
    pair_ready = 1'b1;
    send_run(0, 5);
    pair_ready = 1'b0;
    in_valid = 1'b1;
    in_data.r = 16'sd99;
    in_data.i = 16'sd99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_hold_A", A.r, sc(1));
      chk("t3_hold_B", B.r, sc(5));
      chk("t3_hold_tw", tw_idx, 1);
      chk("t3_hold_pv", pair_valid, 1);
      chk("t3_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pair_ready = 1'b1;
    send_run(6, 7);
    drain();
    chk_pairs("t3", 0, 0, 4);
    chk("t3_npairs", q_a.size(), 4);
    chk("t3_done", n_done, 1);

    // 4: 16 samples, last pair of frame 1 stalled while frame 2 fills
    clear_log();
    pair_ready = 1'b1;
    send_run(0, 7);
    pair_ready = 1'b0;
    send_run(8, 10);
    chk("t4_hold_A", A.r, sc(3));
    chk("t4_hold_B", B.r, sc(7));
    chk("t4_hold_pv", pair_valid, 1);
    pair_ready = 1'b1;
    send_run(11, 15);
    drain();
    chk_pairs("t4a", 0, 0, 4);
    chk_pairs("t4b", 4, 8, 4);
    chk("t4_npairs", q_a.size(), 8);
    chk("t4_done", n_done, 2);

    // 5: reset in the middle of PAIR, then a fresh frame
    clear_log();
    pair_ready = 1'b1;
    send_run(0, 5);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_A", A, 0);
    chk("t5_rst_B", B, 0);
    chk("t5_rst_pv", pair_valid, 0);
    chk("t5_rst_fd", frame_done, 0);
    chk("t5_rst_tw", tw_idx, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_log();
    send_run(20, 27);
    drain();
    chk_pairs("t5", 0, 20, 4);
    chk("t5_npairs", q_a.size(), 4);
    chk("t5_done", n_done, 1);

    // 6: odd magnitudes expose the scaling rounding
    clear_log();
    pair_ready = 1'b1;
    send(7, 0);
    for (int k = 1; k < 4; k++) send(0, 0);
    send(-7, 0);
`ifdef BFLY_FEED_SCALE_EN
    chk("t6_A", A.r, 3);
    chk("t6_B", B.r, -4);
`else
    chk("t6_A", A.r, 7);
    chk("t6_B", B.r, -7);
`endif
    for (int k = 5; k < 8; k++) send(0, 0);
    drain();
    chk("t6_done", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
